// File: rtl/int_arb_pkg.sv
// int_arb_pkg: shared FSM state type, source-count limit and index helper for the interrupt arbiter
package int_arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_SERVICE} int_state_t;

  parameter int N_SRC_MAX = 8;

  function automatic int wrap_inc(input int id, input int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/int_priority_pick.sv
// int_priority_pick: first eligible source found searching upward from start, wrapping at N_SRC
module int_priority_pick #(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] eligible,
  input  logic [ID_W-1:0]  start,
  output logic [ID_W-1:0]  winner,
  output logic             valid
);

  logic [ID_W-1:0] idx;

  // walk from the farthest offset down so the nearest eligible source to start is the last one kept
  always_comb begin
    winner = '0;
    idx    = '0;
    valid  = |eligible;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      idx = ID_W'((int'(start) + i) % N_SRC);
      if (eligible[idx]) winner = idx;
    end
  end

endmodule

// File: rtl/interrupt_arbiter.sv
// interrupt_arbiter: edge-latched, masked interrupt arbiter with global I flag feeding the MCU.
// Define INT_ARB_ROUND_ROBIN_EN for rotating priority; otherwise the lowest index wins.
module interrupt_arbiter
  import int_arb_pkg::*;
#(
  parameter int N_SRC = 4,
  parameter int ID_W  = $clog2(N_SRC)
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [N_SRC-1:0] IRQ,
  input  logic             I_SET,
  input  logic             I_CLR,
  input  logic             INT_ACK,
  input  logic             RETI,
  input  logic             MASK_WE,
  input  logic [N_SRC-1:0] MASK_DATA,
  output logic             INT_R,
  output logic [ID_W-1:0]  INT_ID,
  output logic             I_FLAG,
  output logic [N_SRC-1:0] PENDING,
  output logic [N_SRC-1:0] MASK
);

  int_state_t       state;
  logic [N_SRC-1:0] irq_q;
  logic [N_SRC-1:0] irq_edge;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] win_bit;
  logic [ID_W-1:0]  start;
  logic [ID_W-1:0]  winner;
  logic             win_valid;
  logic             ack_take;
  logic             any_elig;

  assign irq_edge = IRQ & ~irq_q;
  assign eligible = I_FLAG ? (PENDING & MASK) : '0;
  assign any_elig = |eligible;
  assign ack_take = (state == ST_REQ) && INT_ACK && win_valid;
  assign win_bit  = ack_take ? (N_SRC'(1) << winner) : '0;
  assign INT_R    = (state == ST_REQ);

`ifdef INT_ARB_ROUND_ROBIN_EN
  logic [ID_W-1:0] last_id;

  // remember the last serviced source; reset value makes source 0 the first candidate
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) last_id <= ID_W'(N_SRC - 1);
    else if (ack_take) last_id <= winner;
  end

  assign start = ID_W'(wrap_inc(int'(last_id), N_SRC));
`else
  assign start = '0;
`endif

  int_priority_pick #(.N_SRC(N_SRC), .ID_W(ID_W)) u_pick (
    .eligible (eligible),
    .start    (start),
    .winner   (winner),
    .valid    (win_valid)
  );

  // request FSM plus pending, mask, I flag and serviced-ID registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= ST_IDLE;
      irq_q   <= '1;
      PENDING <= '0;
      MASK    <= '0;
      I_FLAG  <= 1'b0;
      INT_ID  <= '0;
    end else begin
      irq_q   <= IRQ;
      MASK    <= MASK_WE ? MASK_DATA : MASK;
      PENDING <= (PENDING & ~win_bit) | irq_edge;
      I_FLAG  <= (ack_take || I_CLR) ? 1'b0 : I_SET ? 1'b1 : I_FLAG;
      INT_ID  <= ack_take ? winner : INT_ID;
      state   <= (state == ST_IDLE) ? (any_elig ? ST_REQ : ST_IDLE) :
                 (state == ST_REQ)  ? (!any_elig ? ST_IDLE : INT_ACK ? ST_SERVICE : ST_REQ) :
                                      (RETI ? ST_IDLE : ST_SERVICE);
    end
  end

endmodule
